updn_mod_counter: RTL and testbench
===================================

UPDN_MOD_COUNTER -- requirements
Module: updn_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4, counter width in bits (2..16).
REQ-002 Parameter MAX_COUNT, default 11, highest legal count value; must be < 2**WIDTH.
REQ-003 Port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port en  input  1  count enable; when low, no up/down step is applied.
REQ-006 Port mode  input  2  direction select: 00 hold, 01 up, 10 down, 11 hold.
REQ-007 Port sat  input  1  boundary policy: 1 saturate, 0 wrap modulo (MAX_COUNT+1).
REQ-008 Port step  input  WIDTH  step magnitude per enabled cycle; 0 means hold.
REQ-009 Port load  input  1  synchronous load request.
REQ-010 Port din  input  WIDTH  load value.
REQ-011 Port clr_flags  input  1  clears the sticky flags.
REQ-012 Port count  output  WIDTH  registered count value.
REQ-013 Port wrap  output  1  registered one-cycle pulse; high in the cycle count first shows a wrapped value.
REQ-014 Port ovf_sticky  output  1  set when an up step crosses MAX_COUNT (wrap or saturate).
REQ-015 Port unf_sticky  output  1  set when a down step crosses 0 (wrap or saturate).
REQ-016 Port load_err  output  1  registered one-cycle pulse; din > MAX_COUNT was clamped.

Function
REQ-017 Update priority is fixed: reset > load > (en and mode up/down) > hold.
REQ-018 load=1 sets count to din when din <= MAX_COUNT; otherwise count is set to MAX_COUNT and load_err pulses for one cycle.
REQ-019 Up step: all sums are computed in WIDTH+1 bits; if count+step <= MAX_COUNT then count becomes count+step.
REQ-020 Up step with count+step > MAX_COUNT: sat=1 gives MAX_COUNT; sat=0 gives count+step-(MAX_COUNT+1) with wrap pulsed; ovf_sticky is set in both cases.
REQ-021 Down step: if step <= count then count becomes count-step.
REQ-022 Down step with step > count: sat=1 gives 0; sat=0 gives count+(MAX_COUNT+1)-step with wrap pulsed; unf_sticky is set in both cases.
REQ-023 A step value > MAX_COUNT+1 is treated as MAX_COUNT+1, i.e. a full-period step.
REQ-024 A saturated count held at its boundary by further same-direction steps re-sets the sticky flag but does not pulse wrap.
REQ-025 When load is applied, no step is applied, wrap stays low, and the sticky flags are not set by that cycle.
REQ-026 clr_flags clears both sticky flags on the next edge; a set event in the same cycle wins (the flag stays 1).
REQ-027 en=0, mode=00/11, or step=0 leave count unchanged, and wrap and load_err are 0 that cycle.
REQ-028 count shall never hold a value > MAX_COUNT after any edge.

Reset
REQ-029 reset=1 immediately and asynchronously forces count=0, wrap=0, ovf_sticky=0, unf_sticky=0, load_err=0.
REQ-030 Reset asserted mid-operation aborts any pending load or step; the first edge after deassertion applies normal priority starting from count=0.

Structure
REQ-031 A shared package updn_counter_pkg holds the mode encoding typedef (MODE_HOLD, MODE_UP, MODE_DOWN) and the default WIDTH/MAX_COUNT constants.
REQ-032 The next-value modulo arithmetic is one sub-module, mod_step_calc: combinational; inputs count, step, direction, sat; outputs next value, crossed flag, wrapped flag.
REQ-033 All outputs are driven from flops in updn_mod_counter; there is no combinational input-to-output path.

Verification (WIDTH=4, MAX_COUNT=11)
REQ-034 Reset, then up, step=1, sat=0, en=1 for 13 cycles -> count 1..11,0,1; wrap high only on the cycle count=0; ovf_sticky=1.
REQ-035 Load din=2, then down, step=3, sat=0 -> count 2 then 11; wrap pulses; unf_sticky=1; then down, step=3 with sat=1 from count=1 -> count 0 with no wrap.
REQ-036 Load din=14 -> count=11 and load_err pulses one cycle; load together with en=1/mode up -> count=din and no step is applied.
REQ-037 Up, step=5, sat=1 from count=9 -> count 11 with ovf_sticky=1; clr_flags together with another crossing step -> ovf_sticky stays 1; clr_flags alone -> 0.
REQ-038 Assert reset asynchronously between edges during counting at count=7 -> outputs are 0 before the next edge; after release, up counting resumes from 0.

Source files
------------

// File: rtl/updn_counter_pkg.sv
// Shared constants and the direction-select encoding for the up/down modulo counter.
package updn_counter_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MAX_COUNT = 11;

  // 2'b11 is an additional hold code and is handled by the default branch
  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10
  } mode_t;

endpackage

// File: rtl/mod_step_calc.sv
// Combinational next-value calculator for one up or down step modulo (MAX_COUNT+1).
module mod_step_calc #(
  parameter int WIDTH     = updn_counter_pkg::DEF_WIDTH,
  parameter int MAX_COUNT = updn_counter_pkg::DEF_MAX_COUNT
) (
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] step,
  input  logic             up,
  input  logic             sat,
  output logic [WIDTH-1:0] next_val,
  output logic             crossed,
  output logic             wrapped
);

  localparam logic [WIDTH:0]   PERIOD_C = (WIDTH+1)'(MAX_COUNT + 1);
  localparam logic [WIDTH:0]   MAX_EXT_C = (WIDTH+1)'(MAX_COUNT);
  localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);

  logic [WIDTH:0]   cnt_ext_s;
  logic [WIDTH:0]   step_eff_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH-1:0] wrap_up_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] wrap_dn_s;

  // Clamp the step to one full period, then select the in-range, saturated or wrapped result
  always_comb begin
    cnt_ext_s  = {1'b0, count};
    step_eff_s = ({1'b0, step} > PERIOD_C) ? PERIOD_C : {1'b0, step};
    sum_s      = cnt_ext_s + step_eff_s;
    wrap_up_s  = WIDTH'(sum_s - PERIOD_C);
    diff_s     = WIDTH'(cnt_ext_s - step_eff_s);
    wrap_dn_s  = WIDTH'(cnt_ext_s + PERIOD_C - step_eff_s);
    next_val   = count;
    crossed    = 1'b0;
    wrapped    = 1'b0;
    if (up) begin
      if (sum_s <= MAX_EXT_C) begin
        next_val = sum_s[WIDTH-1:0];
      end else begin
        crossed = 1'b1;
        if (sat) begin
          next_val = MAX_C;
        end else begin
          next_val = wrap_up_s;
          wrapped  = 1'b1;
        end
      end
    end else begin
      if (step_eff_s <= cnt_ext_s) begin
        next_val = diff_s;
      end else begin
        crossed = 1'b1;
        if (sat) begin
          next_val = {WIDTH{1'b0}};
        end else begin
          next_val = wrap_dn_s;
          wrapped  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/updn_mod_counter.sv
// Up/down modulo counter with load clamp, saturate/wrap policy and sticky crossing flags.
module updn_mod_counter #(
  parameter int WIDTH     = updn_counter_pkg::DEF_WIDTH,
  parameter int MAX_COUNT = updn_counter_pkg::DEF_MAX_COUNT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sat,
  input  logic [WIDTH-1:0] step,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             ovf_sticky,
  output logic             unf_sticky,
  output logic             load_err
);

  import updn_counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] count_r, count_nxt_s, calc_val_s;
  logic             wrap_r, wrap_nxt_s;
  logic             ovf_r, ovf_nxt_s;
  logic             unf_r, unf_nxt_s;
  logic             load_err_r, load_err_nxt_s;
  logic             dir_up_s, stepping_s, crossed_s, wrapped_s;

  mod_step_calc #(
    .WIDTH    (WIDTH),
    .MAX_COUNT(MAX_COUNT)
  ) u_calc (
    .count   (count_r),
    .step    (step),
    .up      (dir_up_s),
    .sat     (sat),
    .next_val(calc_val_s),
    .crossed (crossed_s),
    .wrapped (wrapped_s)
  );

  // Decode direction and whether this cycle applies a step at all
  always_comb begin
    dir_up_s   = 1'b0;
    stepping_s = 1'b0;
    case (mode)
      MODE_UP: begin
        dir_up_s   = 1'b1;
        stepping_s = en && (step != {WIDTH{1'b0}});
      end
      MODE_DOWN: begin
        dir_up_s   = 1'b0;
        stepping_s = en && (step != {WIDTH{1'b0}});
      end
      default: begin
        dir_up_s   = 1'b0;
        stepping_s = 1'b0;
      end
    endcase
  end

  // Next-state selection: load beats step beats hold; a set event beats clr_flags
  always_comb begin
    count_nxt_s    = count_r;
    wrap_nxt_s     = 1'b0;
    load_err_nxt_s = 1'b0;
    ovf_nxt_s      = ovf_r & ~clr_flags;
    unf_nxt_s      = unf_r & ~clr_flags;
    if (load) begin
      if (din > MAX_C) begin
        count_nxt_s    = MAX_C;
        load_err_nxt_s = 1'b1;
      end else begin
        count_nxt_s = din;
      end
    end else if (stepping_s) begin
      count_nxt_s = calc_val_s;
      wrap_nxt_s  = wrapped_s;
      if (crossed_s && dir_up_s) begin
        ovf_nxt_s = 1'b1;
      end else if (crossed_s) begin
        unf_nxt_s = 1'b1;
      end else begin
        ovf_nxt_s = ovf_r & ~clr_flags;
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r    <= {WIDTH{1'b0}};
      wrap_r     <= 1'b0;
      ovf_r      <= 1'b0;
      unf_r      <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      wrap_r     <= wrap_nxt_s;
      ovf_r      <= ovf_nxt_s;
      unf_r      <= unf_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign count      = count_r;
  assign wrap       = wrap_r;
  assign ovf_sticky = ovf_r;
  assign unf_sticky = unf_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_updn_mod_counter.sv
// Directed self-checking bench for updn_mod_counter at WIDTH=4, MAX_COUNT=11.
module tb_updn_mod_counter;

  logic       clock = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic       sat;
  logic [3:0] step;
  logic       load;
  logic [3:0] din;
  logic       clr_flags;
  logic [3:0] count;
  logic       wrap, ovf_sticky, unf_sticky, load_err;

  int n_checks = 0;
  int n_fail   = 0;

  updn_mod_counter #(.WIDTH(4), .MAX_COUNT(11)) dut (
    .clock     (clock),
    .reset     (reset),
    .en        (en),
    .mode      (mode),
    .sat       (sat),
    .step      (step),
    .load      (load),
    .din       (din),
    .clr_flags (clr_flags),
    .count     (count),
    .wrap      (wrap),
    .ovf_sticky(ovf_sticky),
    .unf_sticky(unf_sticky),
    .load_err  (load_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_all(input string tag, input logic [3:0] c, input logic w,
                           input logic o, input logic u, input logic le);
    check({tag, ".count"}, 16'(count), 16'(c));
    check({tag, ".wrap"}, 16'(wrap), 16'(w));
    check({tag, ".ovf"}, 16'(ovf_sticky), 16'(o));
    check({tag, ".unf"}, 16'(unf_sticky), 16'(u));
    check({tag, ".load_err"}, 16'(load_err), 16'(le));
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; sat = 1'b0; step = 4'd0;
    load = 1'b0; din = 4'd0; clr_flags = 1'b0;
    tick(); tick();
    check_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // up by 1, wrap modulo 12
    en = 1'b1; mode = 2'b01; step = 4'd1;
    for (int i = 1; i <= 13; i++) begin
      tick();
      check($sformatf("up1[%0d].count", i), 16'(count), 16'(i % 12));
      check($sformatf("up1[%0d].wrap", i), 16'(wrap), (i == 12) ? 16'd1 : 16'd0);
    end
    check("up1.ovf", 16'(ovf_sticky), 16'd1);
    check("up1.unf", 16'(unf_sticky), 16'd0);

    en = 1'b0; tick();
    check_all("en0_hold", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    en = 1'b1; mode = 2'b11; tick();
    check_all("mode11_hold", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    mode = 2'b01; step = 4'd0; tick();
    check_all("step0_hold", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);

    // load 2, down 3 wraps to 11
    en = 1'b0; load = 1'b1; din = 4'd2; tick();
    check_all("load2", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1; mode = 2'b10; step = 4'd3; sat = 1'b0; tick();
    check_all("dn3_wrap", 4'd11, 1'b1, 1'b1, 1'b1, 1'b0);
    en = 1'b0; load = 1'b1; din = 4'd1; tick();
    check_all("load1", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    load = 1'b0; en = 1'b1; sat = 1'b1; tick();
    check_all("dn3_sat", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    clr_flags = 1'b1; tick();
    check_all("dn_sat_hold_clr", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);

    // clear flags, load clamp and load-over-step priority
    en = 1'b0; tick();
    check_all("clr_both", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_flags = 1'b0; load = 1'b1; din = 4'd14; tick();
    check_all("load14", 4'd11, 1'b0, 1'b0, 1'b0, 1'b1);
    load = 1'b0; tick();
    check_all("load_err_gone", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    load = 1'b1; din = 4'd5; en = 1'b1; mode = 2'b01; step = 4'd3; sat = 1'b0; tick();
    check_all("load_vs_step", 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);

    // saturate up, clr_flags with simultaneous crossing
    en = 1'b0; din = 4'd9; tick();
    load = 1'b0; en = 1'b1; mode = 2'b01; step = 4'd5; sat = 1'b1; tick();
    check_all("up5_sat", 4'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    clr_flags = 1'b1; tick();
    check_all("clr_vs_set", 4'd11, 1'b0, 1'b1, 1'b0, 1'b0);
    en = 1'b0; tick();
    check_all("clr_alone", 4'd11, 1'b0, 1'b0, 1'b0, 1'b0);
    clr_flags = 1'b0;

    // oversize steps clamp to a full period
    load = 1'b1; din = 4'd3; tick();
    load = 1'b0; en = 1'b1; mode = 2'b01; step = 4'd15; sat = 1'b0; tick();
    check_all("up15_full", 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    mode = 2'b10; step = 4'd13; tick();
    check_all("dn13_full", 4'd3, 1'b1, 1'b1, 1'b1, 1'b0);

    // asynchronous reset mid-count at 7
    en = 1'b0; load = 1'b1; din = 4'd5; tick();
    load = 1'b0; en = 1'b1; mode = 2'b01; step = 4'd1; tick(); tick();
    check("pre_rst.count", 16'(count), 16'd7);
    #2 reset = 1'b1;
    #1 check_all("async_rst", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    check("rst_held.count", 16'(count), 16'd0);
    reset = 1'b0; tick();
    check_all("post_rst", 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("post_rst2.count", 16'(count), 16'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
